// File: rtl/fu_issue_queue_pkg.sv
// Shared core types for the FU issue path: control word and issue packet.
package fu_issue_queue_pkg;

  localparam int unsigned REG_VAL_W  = 32;
  localparam int unsigned PHYS_REG_W = 6;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_MUL
  } alu_op_e;

  typedef struct packed {
    alu_op_e op;
    logic    use_imm;
    logic    wr_en;
  } control_t;

  typedef struct packed {
    logic [REG_VAL_W-1:0]  src1_reg_val;
    logic [REG_VAL_W-1:0]  src2_reg_val;
    logic [PHYS_REG_W-1:0] dst_reg_addr;
    control_t              control;
    logic [REG_VAL_W-1:0]  immediate;
  } issue_pkt_t;

endpackage

// File: rtl/fu_issue_queue_issue_fifo.sv
// Single-channel issue FIFO; ready/valid flags are registered from the next count.
module issue_fifo
  import fu_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  issue_pkt_t       push_pkt_i,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output issue_pkt_t       pop_pkt_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             push, pop;
  issue_pkt_t       mem_q [DEPTH];

  assign push = push_valid_i & ready_q & ~flush_i;
  assign pop  = valid_q & pop_ready_i & ~flush_i;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
    ready_d = (cnt_d != CNT_W'(DEPTH));
    valid_d = (cnt_d != CNT_W'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
    end
  end

  // Storage carries no reset; contents are only observed while valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_pkt_i;
  end

  assign push_ready_o = ready_q;
  assign pop_valid_o  = valid_q;
  assign pop_pkt_o    = mem_q[rd_ptr_q];
  assign count_o      = cnt_q;

endmodule

// File: rtl/fu_issue_queue.sv
// Per-FU issue queues: NUM_OF_FU independent FIFOs sharing flush and a pending summary.
module fu_issue_queue
  import fu_issue_queue_pkg::*;
#(
  parameter int unsigned NUM_OF_FU = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_W     = $clog2(DEPTH+1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [NUM_OF_FU-1:0]            rs_valid,
  output logic [NUM_OF_FU-1:0]            rs_ready,
  input  issue_pkt_t                      rs_pkt [NUM_OF_FU],
  output logic [NUM_OF_FU-1:0]            fu_valid,
  input  logic [NUM_OF_FU-1:0]            fu_ready,
  output issue_pkt_t                      fu_pkt [NUM_OF_FU],
  output logic [NUM_OF_FU-1:0][CNT_W-1:0] occupancy,
  output logic                            any_pending
);

  for (genvar g = 0; g < NUM_OF_FU; g++) begin : g_ch
    issue_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (flush),
      .push_valid_i (rs_valid[g]),
      .push_ready_o (rs_ready[g]),
      .push_pkt_i   (rs_pkt[g]),
      .pop_valid_o  (fu_valid[g]),
      .pop_ready_i  (fu_ready[g]),
      .pop_pkt_o    (fu_pkt[g]),
      .count_o      (occupancy[g])
    );
  end

  assign any_pending = |fu_valid;

endmodule

// File: tb/tb_fu_issue_queue.sv
// Directed bench for fu_issue_queue with two channels of depth four.
module tb_fu_issue_queue;
  import fu_issue_queue_pkg::*;

  localparam int unsigned NF = 2;
  localparam int unsigned DP = 4;
  localparam int unsigned CW = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic [NF-1:0]          rs_valid;
  logic [NF-1:0]          rs_ready;
  issue_pkt_t             rs_pkt [NF];
  logic [NF-1:0]          fu_valid;
  logic [NF-1:0]          fu_ready;
  issue_pkt_t             fu_pkt [NF];
  logic [NF-1:0][CW-1:0]  occupancy;
  logic                   any_pending;

  int n_cmp = 0;
  int n_err = 0;

  fu_issue_queue #(.NUM_OF_FU(NF), .DEPTH(DP), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .rs_valid    (rs_valid),
    .rs_ready    (rs_ready),
    .rs_pkt      (rs_pkt),
    .fu_valid    (fu_valid),
    .fu_ready    (fu_ready),
    .fu_pkt      (fu_pkt),
    .occupancy   (occupancy),
    .any_pending (any_pending)
  );

  always #5 clk = ~clk;

  function automatic issue_pkt_t mk(input int d);
    issue_pkt_t p;
    p.src1_reg_val    = 32'(d * 3 + 32'h100);
    p.src2_reg_val    = 32'(d * 5 + 32'h200);
    p.dst_reg_addr    = 6'(d);
    p.control.op      = OP_ADD;
    p.control.use_imm = 1'b0;
    p.control.wr_en   = 1'b1;
    p.immediate       = 32'(d);
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    rs_valid = '0;
    fu_ready = '0;
    rs_pkt[0] = mk(0);
    rs_pkt[1] = mk(0);
    #12;
    check("rst_fu_valid", 32'(fu_valid), 32'h0);
    check("rst_rs_ready", 32'(rs_ready), 32'h3);
    check("rst_occ0", 32'(occupancy[0]), 32'd0);
    check("rst_occ1", 32'(occupancy[1]), 32'd0);
    check("rst_any_pending", 32'(any_pending), 32'd0);
    rst_n = 1'b1;
    step();

    // Fill channel 0 with dst 1..4 while FU stalls.
    for (int i = 1; i <= 4; i++) begin
      rs_valid  = 2'b01;
      rs_pkt[0] = mk(i);
      step();
      check("fill_occ0", 32'(occupancy[0]), 32'(i));
      check("fill_head", 32'(fu_pkt[0].dst_reg_addr), 32'd1);
    end
    rs_valid = '0;
    check("full_rs_ready0", 32'(rs_ready[0]), 32'd0);
    check("full_ch1_ready", 32'(rs_ready[1]), 32'd1);
    check("full_ch1_valid", 32'(fu_valid[1]), 32'd0);
    check("full_ch1_occ", 32'(occupancy[1]), 32'd0);
    check("full_any_pending", 32'(any_pending), 32'd1);

    // Drain in order.
    fu_ready = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", 32'(fu_valid[0]), 32'd1);
      check("drain_dst", 32'(fu_pkt[0].dst_reg_addr), 32'(i));
      check("drain_src1", fu_pkt[0].src1_reg_val, 32'(i * 3 + 32'h100));
      step();
    end
    fu_ready = '0;
    check("drained_valid", 32'(fu_valid[0]), 32'd0);
    check("drained_occ", 32'(occupancy[0]), 32'd0);
    check("drained_ready", 32'(rs_ready[0]), 32'd1);

    // Pointers have wrapped: a new entry lands in slot 0 and comes out next.
    rs_valid  = 2'b01;
    rs_pkt[0] = mk(7);
    step();
    rs_valid = '0;
    check("wrap_dst", 32'(fu_pkt[0].dst_reg_addr), 32'd7);
    fu_ready = 2'b01;
    step();
    fu_ready = '0;
    check("wrap_empty", 32'(fu_valid[0]), 32'd0);

    // Full channel with simultaneous push and pop: push rejected.
    for (int i = 10; i <= 13; i++) begin
      rs_valid  = 2'b01;
      rs_pkt[0] = mk(i);
      step();
    end
    check("refill_occ", 32'(occupancy[0]), 32'd4);
    rs_pkt[0] = mk(14);
    fu_ready  = 2'b01;
    step();
    rs_valid = '0;
    fu_ready = '0;
    check("fullpp_occ", 32'(occupancy[0]), 32'd3);
    check("fullpp_ready", 32'(rs_ready[0]), 32'd1);
    check("fullpp_head", 32'(fu_pkt[0].dst_reg_addr), 32'd11);

    // Empty channel 1 with push and fu_ready together.
    rs_valid  = 2'b10;
    rs_pkt[1] = mk(20);
    fu_ready  = 2'b10;
    #1;
    check("emptypp_valid_before", 32'(fu_valid[1]), 32'd0);
    step();
    rs_valid = '0;
    fu_ready = '0;
    check("emptypp_valid_after", 32'(fu_valid[1]), 32'd1);
    check("emptypp_occ", 32'(occupancy[1]), 32'd1);
    check("emptypp_head", 32'(fu_pkt[1].dst_reg_addr), 32'd20);

    // Bring channel 1 to 3 entries, then flush with concurrent traffic.
    for (int i = 21; i <= 22; i++) begin
      rs_valid  = 2'b10;
      rs_pkt[1] = mk(i);
      step();
    end
    rs_valid = '0;
    check("preflush_occ0", 32'(occupancy[0]), 32'd3);
    check("preflush_occ1", 32'(occupancy[1]), 32'd3);
    flush     = 1'b1;
    rs_valid  = 2'b11;
    rs_pkt[0] = mk(40);
    rs_pkt[1] = mk(41);
    fu_ready  = 2'b11;
    #1;
    check("flush_rs_ready", 32'(rs_ready), 32'h3);
    step();
    flush    = 1'b0;
    rs_valid = '0;
    fu_ready = '0;
    check("postflush_occ0", 32'(occupancy[0]), 32'd0);
    check("postflush_occ1", 32'(occupancy[1]), 32'd0);
    check("postflush_valid", 32'(fu_valid), 32'h0);
    check("postflush_pending", 32'(any_pending), 32'd0);
    check("postflush_ready", 32'(rs_ready), 32'h3);

    // Asynchronous reset mid-stream.
    rs_valid  = 2'b11;
    rs_pkt[0] = mk(30);
    rs_pkt[1] = mk(33);
    step();
    rs_valid = '0;
    check("prerst_occ0", 32'(occupancy[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(fu_valid), 32'h0);
    check("async_ready", 32'(rs_ready), 32'h3);
    check("async_occ0", 32'(occupancy[0]), 32'd0);
    check("async_occ1", 32'(occupancy[1]), 32'd0);
    check("async_pending", 32'(any_pending), 32'd0);
    #2;
    rst_n = 1'b1;
    rs_valid  = 2'b01;
    rs_pkt[0] = mk(31);
    step();
    rs_valid = '0;
    check("restart_occ0", 32'(occupancy[0]), 32'd1);
    check("restart_head", 32'(fu_pkt[0].dst_reg_addr), 32'd31);
    check("restart_occ1", 32'(occupancy[1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fu_issue_queue.md
FU_ISSUE_QUEUE -- requirements
Module: fu_issue_queue

Interface
REQ-001 Parameter NUM_OF_FU, default 4, number of independent FU issue channels.
REQ-002 Parameter DEPTH, default 4, entries per channel; power of two, >= 2.
REQ-003 Parameter CNT_W, default $clog2(DEPTH+1), occupancy count width.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous squash of all channels (branch mispredict).
REQ-007 rs_valid  input  [NUM_OF_FU-1:0]  per-channel issue request from reservation station.
REQ-008 rs_ready  output  [NUM_OF_FU-1:0]  per-channel space available.
REQ-009 rs_pkt  input  issue_pkt_t [NUM_OF_FU]  src1_reg_val, src2_reg_val, dst_reg_addr, control, immediate.
REQ-010 fu_valid  output  [NUM_OF_FU-1:0]  per-channel head entry valid.
REQ-011 fu_ready  input  [NUM_OF_FU-1:0]  per-channel FU accepts head.
REQ-012 fu_pkt  output  issue_pkt_t [NUM_OF_FU]  per-channel head packet.
REQ-013 occupancy  output  CNT_W x NUM_OF_FU  per-channel entry count.
REQ-014 any_pending  output  1  OR of all fu_valid bits.

Function
REQ-015 Each channel SHALL be an independent DEPTH-entry FIFO; channels never interact except via flush and any_pending.
REQ-016 Push occurs on a channel when rs_valid & rs_ready are both high at a rising edge and flush is low.
REQ-017 Pop occurs on a channel when fu_valid & fu_ready are both high at a rising edge and flush is low.
REQ-018 rs_ready SHALL equal (occupancy != DEPTH), from registered state only; no combinational path from fu_ready.
REQ-019 fu_valid SHALL equal (occupancy != 0), from registered state only; no combinational path from rs_valid.
REQ-020 fu_pkt SHALL be the oldest unpopped entry; contents undefined-but-stable while fu_valid low.
REQ-021 Minimum latency rs push to fu_valid high: 1 cycle (no same-cycle bypass).
REQ-022 Simultaneous push and pop on a non-full, non-empty channel: occupancy unchanged, order preserved.
REQ-023 Simultaneous push and pop on an empty channel: only push happens (fu_valid low that cycle).
REQ-024 Full channel: rs_ready low; pop that cycle frees one slot, rs_ready high next cycle.
REQ-025 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-026 occupancy SHALL update +1 push-only, -1 pop-only, 0 otherwise; never exceed DEPTH or underflow.
REQ-027 flush high at an edge: all channels' pointers and occupancy cleared; concurrent push/pop ignored; flush wins.
REQ-028 While flush high, rs_ready reflects pre-flush state; RS must not count a flush-cycle handshake as accepted.
REQ-029 Once a head entry has fu_valid high, it and fu_pkt SHALL hold until popped or flushed.

Reset
REQ-030 rst_n low SHALL immediately clear all pointers and occupancy: fu_valid=0, rs_ready=all 1, occupancy=0, any_pending=0.
REQ-031 Storage array SHALL NOT be reset; fu_pkt value after reset is don't-care.
REQ-032 Reset asserted mid-transfer discards all entries; first edge after rst_n release behaves as from empty.

Structure
REQ-033 issue_pkt_t typedef (using control_t, `REG_VAL_WIDTH, `PHYSICAL_REG_NUM_WIDTH) SHALL live in the shared core package.
REQ-034 One sub-module issue_fifo (single channel, parametrised DEPTH) SHALL be instantiated NUM_OF_FU times via generate.
REQ-035 Top level SHALL contain only the generate loop, flush fan-out and any_pending reduction.

Verification (NUM_OF_FU=2, DEPTH=4)
REQ-036 Fill ch0 with pkts dst=1..4, fu_ready=0 -> rs_ready[0]=0 after 4th push, occupancy[0]=4, ch1 unaffected.
REQ-037 Then fu_ready[0]=1 for 4 cycles -> dst 1,2,3,4 out in order, fu_valid[0]=0 after, pointers wrapped.
REQ-038 Full ch0 with push+pop same cycle -> push rejected, occupancy 4->3, rs_ready[0]=1 next cycle.
REQ-039 Empty ch1, rs_valid+fu_ready same cycle -> fu_valid[1]=0 that cycle, 1 next cycle, occupancy[1]=1.
REQ-040 Both channels at occupancy 3, flush with concurrent push/pop -> next cycle occupancy=0/0, any_pending=0.
REQ-041 rst_n pulsed low mid-stream asynchronously -> outputs cleared before next clk edge, restart from empty.
